// File: rtl/button_gesture.sv
// ----------------------------------------------------------------------------
// button_gesture
//
// Turns debounced press/release pulses from a single push button into
// gesture pulses: single click, double click, long press, and an
// auto-repeat tick while the button stays held after a long press.
//
// Ports
//   i_clk           rising-edge clock for all logic
//   i_rst_n         synchronous active-low reset
//   i_btn_down      1-cycle pulse, debounced press
//   i_btn_up        1-cycle pulse, debounced release
//   o_single_click  1-cycle pulse, press+release with no second press in time
//   o_double_click  1-cycle pulse, second press released inside the window
//   o_long_press    1-cycle pulse, press held for LONG_CYCLES
//   o_hold_repeat   1-cycle pulse every REPEAT_CYCLES after a long press
//   o_busy          high whenever a gesture is in progress (state != IDLE)
//
// Parameters (all legal from 1 to 2^32-1)
//   LONG_CYCLES     hold time before a long press
//   DCLICK_CYCLES   release window in which a second press makes a double
//   REPEAT_CYCLES   auto-repeat period while held after a long press
// ----------------------------------------------------------------------------
module button_gesture #(
   parameter int unsigned LONG_CYCLES   = 50_000_000,
   parameter int unsigned DCLICK_CYCLES = 12_500_000,
   parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn_down,
   input  logic i_btn_up,
   output logic o_single_click,
   output logic o_double_click,
   output logic o_long_press,
   output logic o_hold_repeat,
   output logic o_busy
);

   typedef enum logic [2:0] {
      IDLE,
      PRESSED,
      WAIT2,
      PRESSED2,
      LONG_HELD
   } state_t;

   // Terminal counts: the counter reads N-1 on the Nth edge spent in a state,
   // so comparing against N-1 makes the exit happen exactly N edges after entry.
   localparam logic [31:0] LONG_TC   = LONG_CYCLES - 1;
   localparam logic [31:0] DCLICK_TC = DCLICK_CYCLES - 1;
   localparam logic [31:0] REPEAT_TC = REPEAT_CYCLES - 1;

   state_t      r_state;
   state_t      w_nextState;
   logic [31:0] r_cnt;
   logic [31:0] w_nextCnt;
   logic        w_cntClr;
   logic        w_down;
   logic        w_up;
   logic        w_single;
   logic        w_double;
   logic        w_long;
   logic        w_repeat;
   logic        r_single;
   logic        r_double;
   logic        r_long;
   logic        r_repeat;
   logic        r_busy;

   // A press and a release on the same edge cannot both be real, so such an
   // edge is treated as if neither pulse had arrived.
   assign w_down = i_btn_down & ~i_btn_up;
   assign w_up   = i_btn_up   & ~i_btn_down;

   // Next-state and pulse decode. Button events always win over a timeout
   // landing on the same edge. In LONG_HELD the repeat tick keeps the state
   // but restarts the counter, so w_cntClr requests that clear explicitly.
   always_comb begin
      w_nextState = r_state;
      w_cntClr    = 1'b0;
      w_single    = 1'b0;
      w_double    = 1'b0;
      w_long      = 1'b0;
      w_repeat    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_down) begin
               w_nextState = PRESSED;
            end
         end
         PRESSED: begin
            if (w_up) begin
               w_nextState = WAIT2;
            end else if (r_cnt == LONG_TC) begin
               w_nextState = LONG_HELD;
               w_long      = 1'b1;
            end
         end
         WAIT2: begin
            if (w_down) begin
               w_nextState = PRESSED2;
            end else if (r_cnt == DCLICK_TC) begin
               w_nextState = IDLE;
               w_single    = 1'b1;
            end
         end
         PRESSED2: begin
            if (w_up) begin
               w_nextState = IDLE;
               w_double    = 1'b1;
            end
         end
         LONG_HELD: begin
            if (w_up) begin
               w_nextState = IDLE;
            end else if (r_cnt == REPEAT_TC) begin
               w_repeat = 1'b1;
               w_cntClr = 1'b1;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Counter update. Timed states always leave before the counter can
   // overflow; the untimed states (IDLE, PRESSED2) may sit forever, so the
   // counter saturates there instead of wrapping.
   always_comb begin
      w_nextCnt = r_cnt;
      if ((w_nextState != r_state) || w_cntClr) begin
         w_nextCnt = 32'd0;
      end else if (r_cnt != 32'hFFFF_FFFF) begin
         w_nextCnt = r_cnt + 32'd1;
      end
   end

   // State, counter and registered outputs. Busy is derived from the next
   // state so it lines up with the state register on every edge.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= 32'd0;
         r_single <= 1'b0;
         r_double <= 1'b0;
         r_long   <= 1'b0;
         r_repeat <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_cnt    <= w_nextCnt;
         r_single <= w_single;
         r_double <= w_double;
         r_long   <= w_long;
         r_repeat <= w_repeat;
         r_busy   <= (w_nextState != IDLE);
      end
   end

   assign o_single_click = r_single;
   assign o_double_click = r_double;
   assign o_long_press   = r_long;
   assign o_hold_repeat  = r_repeat;
   assign o_busy         = r_busy;

endmodule

// File: doc/button_gesture.md
BUTTON_GESTURE -- requirements
Module: button_gesture

Interface
REQ-001 Parameter: LONG_CYCLES, default 50_000_000, press-hold cycles before a long press; legal range 1 to 2^32-1.
REQ-002 Parameter: DCLICK_CYCLES, default 12_500_000, release window for a second press; legal range 1 to 2^32-1.
REQ-003 Parameter: REPEAT_CYCLES, default 10_000_000, auto-repeat period after a long press; legal range 1 to 2^32-1.
REQ-004 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 btn_down  input  1  1-cycle pulse from the upstream debouncer marking a debounced press.
REQ-007 btn_up  input  1  1-cycle pulse from the upstream debouncer marking a debounced release.
REQ-008 single_click  output  1  registered 1-cycle pulse: press and release with no second press in the window.
REQ-009 double_click  output  1  registered 1-cycle pulse: second press released inside the window.
REQ-010 long_press  output  1  registered 1-cycle pulse: press held LONG_CYCLES.
REQ-011 hold_repeat  output  1  registered 1-cycle pulse every REPEAT_CYCLES while held after long_press.
REQ-012 busy  output  1  registered; 1 whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly these states: IDLE, PRESSED, WAIT2, PRESSED2, LONG_HELD.
REQ-014 A 32-bit cycle counter cnt SHALL clear to 0 on every state transition and increment by 1 on each cycle the state is held; it SHALL never wrap, because every timed state exits at its terminal count.
REQ-015 IDLE: btn_down -> PRESSED; btn_up ignored.
REQ-016 PRESSED: btn_up -> WAIT2, with priority over the timeout; else cnt==LONG_CYCLES-1 -> LONG_HELD, with long_press=1 on the next cycle; btn_down ignored.
REQ-017 WAIT2: btn_down -> PRESSED2, with priority over the timeout; else cnt==DCLICK_CYCLES-1 -> IDLE, with single_click=1 on the next cycle.
REQ-018 PRESSED2: btn_up -> IDLE, with double_click=1 on the next cycle; no timeout; no long press is detected in this state.
REQ-019 LONG_HELD: btn_up -> IDLE, with priority over repeat, and no pulse; else cnt==REPEAT_CYCLES-1 -> hold_repeat=1 on the next cycle, cnt cleared, state unchanged.
REQ-020 btn_down and btn_up both high on the same edge SHALL be ignored: no transition, and cnt behaves as if neither were high.
REQ-021 Latency: long_press SHALL assert exactly LONG_CYCLES edges after the edge that sampled btn_down.
REQ-022 Latency: single_click SHALL assert exactly DCLICK_CYCLES edges after the edge that sampled btn_up.
REQ-023 Each output pulse SHALL last exactly 1 cycle.
REQ-024 At most one of single_click, double_click, long_press and hold_repeat SHALL be high in any cycle.
REQ-025 busy SHALL reflect the state register after each edge, with zero added latency relative to state.

Reset
REQ-026 rst_n==0 sampled on an edge SHALL force state=IDLE, cnt=0 and all outputs to 0 on that edge, regardless of the other inputs.
REQ-027 Reset asserted mid-gesture in any state SHALL discard the gesture with no pulse; input pulses sampled while rst_n==0 SHALL be ignored.
REQ-028 After release of reset, the first accepted event SHALL be a btn_down sampled on an edge with rst_n==1.

Verification
Bench parameters: LONG_CYCLES=8, DCLICK_CYCLES=4, REPEAT_CYCLES=3.
REQ-029 Single click: btn_down at edge 0, btn_up at edge 3 -> single_click=1 only after edge 7; busy=1 from edge 0 through edge 6 and 0 after edge 7.
REQ-030 Double click: down@0, up@2, down@4, up@6 -> double_click=1 after edge 6; single_click never asserts.
REQ-031 Long press with repeat: down@0, up@16 -> long_press after edge 8; hold_repeat after edges 11 and 14; none after edge 16.
REQ-032 Boundary priority: down@0, up@8 -> no long_press, state WAIT2.
REQ-033 Boundary priority: down@0, up@2, down@6 (cnt==3 in WAIT2) -> PRESSED2, no single_click.
REQ-034 Reset and simultaneous inputs: rst_n=0 at edge 5 of the REQ-031 case -> no pulses afterward, busy=0 after edge 5; separately, down and up together in IDLE -> no state change.
